// File: rtl/i2c_slave_regfile.sv
// I2C target with an auto-incrementing byte register file, clocked by the system clock.
// SCL/SDA are oversampled; every bus action keys off synchronised edge/START/STOP events.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h05,
  parameter int         DEPTH      = 16,
  parameter bit         MSB_FIRST  = 1'b1,
  localparam int        PTR_W      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic             busy,
  output logic             reg_wr,
  output logic [PTR_W-1:0] reg_wr_addr,
  output logic [7:0]       reg_wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [7:0]       rd_data
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         bitcnt_q, bitcnt_d;
  logic [7:0]         shreg_q, shreg_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               rw_q, rw_d;
  logic               busy_q, busy_d;
  logic               oe_q, oe_d;
  logic               wr_pend_q, wr_pend_d;
  logic               scl_s1_q, scl_s2_q, scl_p_q;
  logic               sda_s1_q, sda_s2_q, sda_p_q;
  logic               reg_wr_q;
  logic [PTR_W-1:0]   reg_wr_addr_q;
  logic [7:0]         reg_wr_data_q, rd_data_q;
  logic [7:0]         mem_q [DEPTH];

  logic scl_rise, scl_fall, bus_start, bus_stop;

  function automatic logic [7:0] shift_in(input logic [7:0] sh, input logic b);
    return MSB_FIRST ? {sh[6:0], b} : {b, sh[7:1]};
  endfunction

  function automatic logic tx_bit(input logic [7:0] byte_v, input logic [2:0] idx);
    return MSB_FIRST ? byte_v[3'd7 - idx] : byte_v[idx];
  endfunction

  assign scl_rise  =  scl_s2_q & ~scl_p_q;
  assign scl_fall  = ~scl_s2_q &  scl_p_q;
  assign bus_start =  scl_s2_q &  scl_p_q &  sda_p_q & ~sda_s2_q;
  assign bus_stop  =  scl_s2_q &  scl_p_q & ~sda_p_q &  sda_s2_q;

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    busy_d    = busy_q;
    oe_d      = oe_q;
    wr_pend_d = 1'b0;
    // The write itself happens in the sequential block; advance the pointer alongside it.
    if (wr_pend_q) ptr_d = ptr_q + PTR_W'(1);
    if (bus_start) begin
      state_d  = ADDR;
      bitcnt_d = 4'd0;
      oe_d     = 1'b0;
    end else if (bus_stop) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        ADDR, PTR, WDATA: if (bitcnt_q < 4'd8) begin
          shreg_d  = shift_in(shreg_q, sda_s2_q);
          bitcnt_d = bitcnt_q + 4'd1;
          if (state_q == WDATA && bitcnt_q == 4'd7) wr_pend_d = 1'b1;
        end
        RDATA: if (bitcnt_q < 4'd8) bitcnt_d = bitcnt_q + 4'd1;
        RACK: if (bitcnt_q == 4'd0) begin
          if (!sda_s2_q) begin
            ptr_d    = ptr_q + PTR_W'(1);
            bitcnt_d = 4'd1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            oe_d    = 1'b0;
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        ADDR: if (bitcnt_q == 4'd8) begin
          if (shreg_q[7:1] == SLAVE_ADDR) begin
            busy_d  = 1'b1;
            oe_d    = 1'b1;
            rw_d    = shreg_q[0];
            state_d = ADDR_ACK;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
        ADDR_ACK: begin
          bitcnt_d = 4'd0;
          if (rw_q) begin
            shreg_d = mem_q[ptr_q];
            oe_d    = ~tx_bit(mem_q[ptr_q], 3'd0);
            state_d = RDATA;
          end else begin
            oe_d    = 1'b0;
            state_d = PTR;
          end
        end
        PTR: if (bitcnt_q == 4'd8) begin
          ptr_d   = shreg_q[PTR_W-1:0];
          oe_d    = 1'b1;
          state_d = PTR_ACK;
        end
        WDATA: if (bitcnt_q == 4'd8) begin
          oe_d    = 1'b1;
          state_d = WDATA_ACK;
        end
        PTR_ACK, WDATA_ACK: begin
          oe_d     = 1'b0;
          bitcnt_d = 4'd0;
          state_d  = WDATA;
        end
        RDATA: begin
          if (bitcnt_q < 4'd8) begin
            oe_d = ~tx_bit(shreg_q, bitcnt_q[2:0]);
          end else begin
            oe_d     = 1'b0;
            bitcnt_d = 4'd0;
            state_d  = RACK;
          end
        end
        // Master ACKed: present the next byte on the fall that ends the ACK clock.
        RACK: if (bitcnt_q == 4'd1) begin
          shreg_d  = mem_q[ptr_q];
          oe_d     = ~tx_bit(mem_q[ptr_q], 3'd0);
          bitcnt_d = 4'd0;
          state_d  = RDATA;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      scl_s1_q      <= 1'b1;
      scl_s2_q      <= 1'b1;
      scl_p_q       <= 1'b1;
      sda_s1_q      <= 1'b1;
      sda_s2_q      <= 1'b1;
      sda_p_q       <= 1'b1;
      state_q       <= IDLE;
      bitcnt_q      <= 4'd0;
      shreg_q       <= 8'h00;
      ptr_q         <= '0;
      rw_q          <= 1'b0;
      busy_q        <= 1'b0;
      oe_q          <= 1'b0;
      wr_pend_q     <= 1'b0;
      reg_wr_q      <= 1'b0;
      reg_wr_addr_q <= '0;
      reg_wr_data_q <= 8'h00;
      rd_data_q     <= 8'h00;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      scl_s1_q  <= scl_i;
      scl_s2_q  <= scl_s1_q;
      scl_p_q   <= scl_s2_q;
      sda_s1_q  <= sda_i;
      sda_s2_q  <= sda_s1_q;
      sda_p_q   <= sda_s2_q;
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      busy_q    <= busy_d;
      oe_q      <= oe_d;
      wr_pend_q <= wr_pend_d;
      reg_wr_q  <= wr_pend_q;
      if (wr_pend_q) begin
        mem_q[ptr_q]  <= shreg_q;
        reg_wr_addr_q <= ptr_q;
        reg_wr_data_q <= shreg_q;
      end
      // Write-first: a same-cycle write to the read index is forwarded.
      rd_data_q <= (wr_pend_q && ptr_q == rd_addr) ? shreg_q : mem_q[rd_addr];
    end
  end

  assign sda_oe      = oe_q;
  assign busy        = busy_q;
  assign reg_wr      = reg_wr_q;
  assign reg_wr_addr = reg_wr_addr_q;
  assign reg_wr_data = reg_wr_data_q;
  assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: a bit-level bus master drives an MSB-first and an LSB-first
// instance; bytes seen on the bus and on reg_wr are compared with an array model of the register file.
module tb_i2c_slave_regfile;
  localparam int Q = 5;

  logic clk = 1'b0;
  logic RESET = 1'b1;
  logic scl_m = 1'b1, sda_m = 1'b1, sel = 1'b0;
  logic [3:0] rd_addr_a = 4'd0, rd_addr_b = 4'd0;
  logic sda_oe_a, busy_a, reg_wr_a, sda_oe_b, busy_b, reg_wr_b;
  logic [3:0] reg_wr_addr_a, reg_wr_addr_b;
  logic [7:0] reg_wr_data_a, reg_wr_data_b, rd_data_a, rd_data_b;
  logic line_a, line_b;

  int checks = 0, failures = 0;
  logic [7:0] mem [16];
  int mptr = 0;
  logic [11:0] exp_wr[$];
  logic [11:0] wrq_a[$];
  int oe_cnt_a = 0, busy_cnt_a = 0;

  assign line_a = sda_m & ~sda_oe_a;
  assign line_b = sda_m & ~sda_oe_b;

  always #5 clk = ~clk;

  i2c_slave_regfile #(.SLAVE_ADDR(7'h05), .DEPTH(16), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .RESET(RESET), .scl_i(scl_m), .sda_i(line_a), .sda_oe(sda_oe_a), .busy(busy_a),
    .reg_wr(reg_wr_a), .reg_wr_addr(reg_wr_addr_a), .reg_wr_data(reg_wr_data_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a));

  i2c_slave_regfile #(.SLAVE_ADDR(7'h05), .DEPTH(16), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .RESET(RESET), .scl_i(scl_m), .sda_i(line_b), .sda_oe(sda_oe_b), .busy(busy_b),
    .reg_wr(reg_wr_b), .reg_wr_addr(reg_wr_addr_b), .reg_wr_data(reg_wr_data_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b));

  always @(negedge clk) begin
    if (reg_wr_a === 1'b1) wrq_a.push_back({reg_wr_addr_a, reg_wr_data_a});
    if (sda_oe_a === 1'b1) oe_cnt_a <= oe_cnt_a + 1;
    if (busy_a === 1'b1) busy_cnt_a <= busy_cnt_a + 1;
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_clear();
    foreach (mem[i]) mem[i] = 8'h00;
    mptr = 0;
  endtask

  task automatic m_write(input logic [7:0] d);
    exp_wr.push_back({4'(mptr), d});
    mem[mptr] = d;
    mptr = (mptr + 1) % 16;
  endtask

  task automatic bus_bit(input logic b, output logic rb);
    clks(Q); sda_m = b;
    clks(Q); scl_m = 1'b1;
    clks(Q); rb = sel ? line_b : line_a;
    clks(Q); scl_m = 1'b0;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; clks(Q);
    scl_m = 1'b1; clks(2*Q);
    sda_m = 1'b0; clks(2*Q);
    scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    clks(Q); sda_m = 1'b0;
    clks(Q); scl_m = 1'b1;
    clks(2*Q); sda_m = 1'b1;
    clks(2*Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic msb, output logic ack);
    logic rb;
    for (int i = 0; i < 8; i++) bus_bit(msb ? b[7-i] : b[i], rb);
    bus_bit(1'b1, rb);
    ack = ~rb;
  endtask

  task automatic recv_byte(input logic msb, input logic mack, output logic [7:0] b);
    logic rb;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bus_bit(1'b1, rb);
      if (msb) b[7-i] = rb; else b[i] = rb;
    end
    bus_bit(~mack, rb);
  endtask

  task automatic read_reg_a(input int idx, output logic [7:0] v);
    rd_addr_a = 4'(idx);
    clks(2);
    v = rd_data_a;
  endtask

  task automatic test_reset();
    clks(4);
    checks++; if (sda_oe_a !== 1'b0) begin failures++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    checks++; if (reg_wr_a !== 1'b0) begin failures++; $display("FAIL reset_reg_wr got=%b exp=0", reg_wr_a); end
    checks++; if (reg_wr_addr_a !== 4'h0) begin failures++; $display("FAIL reset_wr_addr got=%h exp=0", reg_wr_addr_a); end
    checks++; if (reg_wr_data_a !== 8'h00) begin failures++; $display("FAIL reset_wr_data got=%h exp=00", reg_wr_data_a); end
    checks++; if (rd_data_a !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%h exp=00", rd_data_a); end
    checks++; if (sda_oe_b !== 1'b0) begin failures++; $display("FAIL reset_sda_oe_b got=%b exp=0", sda_oe_b); end
    RESET = 1'b0;
    m_clear();
    clks(4);
  endtask

  task automatic test_write_burst();
    logic a0, a1, a2, a3;
    logic [7:0] v;
    wrq_a.delete(); exp_wr.delete();
    bus_start();
    send_byte(8'h0A, 1'b1, a0);
    send_byte(8'h03, 1'b1, a1); mptr = 3;
    send_byte(8'hCC, 1'b1, a2); m_write(8'hCC);
    send_byte(8'h5A, 1'b1, a3); m_write(8'h5A);
    bus_stop();
    checks++; if ({a0, a1, a2, a3} !== 4'hF) begin failures++; $display("FAIL wb_acks got=%b exp=1111", {a0, a1, a2, a3}); end
    checks++; if (wrq_a.size() != exp_wr.size()) begin failures++; $display("FAIL wb_wr_count got=%0d exp=%0d", wrq_a.size(), exp_wr.size()); end
    foreach (exp_wr[i]) begin
      checks++;
      if (i >= wrq_a.size() || wrq_a[i] !== exp_wr[i]) begin
        failures++; $display("FAIL wb_reg_wr[%0d] got=%h exp=%h", i, (i < wrq_a.size()) ? wrq_a[i] : 12'hxxx, exp_wr[i]);
      end
    end
    read_reg_a(4, v);
    checks++; if (v !== mem[4]) begin failures++; $display("FAIL wb_rd_data4 got=%h exp=%h", v, mem[4]); end
  endtask

  task automatic test_repeated_start_read();
    logic a0, a1, a2;
    logic [7:0] b0, b1;
    bus_start();
    send_byte(8'h0A, 1'b1, a0);
    send_byte(8'h03, 1'b1, a1); mptr = 3;
    bus_start();
    send_byte(8'h0B, 1'b1, a2);
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL rs_busy_high got=%b exp=1", busy_a); end
    recv_byte(1'b1, 1'b1, b0);
    checks++; if (b0 !== mem[3]) begin failures++; $display("FAIL rs_byte0 got=%h exp=%h", b0, mem[3]); end
    mptr = 4;
    recv_byte(1'b1, 1'b0, b1);
    checks++; if (b1 !== mem[4]) begin failures++; $display("FAIL rs_byte1 got=%h exp=%h", b1, mem[4]); end
    clks(2);
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rs_busy_after_nack got=%b exp=0", busy_a); end
    checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL rs_acks got=%b exp=111", {a0, a1, a2}); end
    bus_stop();
  endtask

  task automatic test_mismatch();
    int oe0, bz0, wq0;
    logic a;
    logic [3:0] acks;
    oe0 = oe_cnt_a; bz0 = busy_cnt_a; wq0 = wrq_a.size();
    bus_start();
    send_byte(8'h0C, 1'b1, a); acks[0] = a;
    for (int i = 1; i < 4; i++) begin send_byte(8'hFF, 1'b1, a); acks[i] = a; end
    bus_stop();
    checks++; if (acks !== 4'h0) begin failures++; $display("FAIL mm_acks got=%b exp=0000", acks); end
    checks++; if (oe_cnt_a != oe0) begin failures++; $display("FAIL mm_sda_oe cycles got=%0d exp=%0d", oe_cnt_a, oe0); end
    checks++; if (busy_cnt_a != bz0) begin failures++; $display("FAIL mm_busy cycles got=%0d exp=%0d", busy_cnt_a, bz0); end
    checks++; if (wrq_a.size() != wq0) begin failures++; $display("FAIL mm_reg_wr got=%0d exp=%0d", wrq_a.size(), wq0); end
  endtask

  task automatic test_wrap();
    logic a;
    logic [7:0] v, d;
    d = 8'($urandom);
    wrq_a.delete(); exp_wr.delete();
    bus_start();
    send_byte(8'h0A, 1'b1, a); send_byte(8'h0F, 1'b1, a); mptr = 8'h0F % 16;
    send_byte(8'h11, 1'b1, a); m_write(8'h11);
    send_byte(8'h22, 1'b1, a); m_write(8'h22);
    bus_stop();
    read_reg_a(15, v);
    checks++; if (v !== 8'h11) begin failures++; $display("FAIL wrap_reg15 got=%h exp=11", v); end
    read_reg_a(0, v);
    checks++; if (v !== 8'h22) begin failures++; $display("FAIL wrap_reg0 got=%h exp=22", v); end
    bus_start();
    send_byte(8'h0A, 1'b1, a); send_byte(8'h1F, 1'b1, a); mptr = 8'h1F % 16;
    send_byte(d, 1'b1, a); m_write(d);
    bus_stop();
    read_reg_a(15, v);
    checks++; if (v !== d) begin failures++; $display("FAIL wrap_ptr1F_reg15 got=%h exp=%h", v, d); end
    checks++; if (wrq_a.size() != 3 || wrq_a[2] !== exp_wr[2]) begin
      failures++; $display("FAIL wrap_reg_wr_count got=%0d exp=3", wrq_a.size());
    end
  endtask

  task automatic test_random_bursts();
    logic a;
    logic [7:0] p, d, b, e;
    int n, nack;
    for (int it = 0; it < 4; it++) begin
      p = 8'($urandom); n = $urandom_range(1, 4); nack = 0;
      wrq_a.delete(); exp_wr.delete();
      bus_start();
      send_byte(8'h0A, 1'b1, a); if (!a) nack++;
      send_byte(p, 1'b1, a); if (!a) nack++;
      mptr = p % 16;
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom);
        send_byte(d, 1'b1, a); if (!a) nack++;
        m_write(d);
      end
      bus_stop();
      checks++; if (nack != 0) begin failures++; $display("FAIL rnd_write_acks it=%0d got=%0d nacks exp=0", it, nack); end
      checks++; if (wrq_a.size() != exp_wr.size()) begin failures++; $display("FAIL rnd_wr_count it=%0d got=%0d exp=%0d", it, wrq_a.size(), exp_wr.size()); end
      foreach (exp_wr[i]) begin
        checks++;
        if (i >= wrq_a.size() || wrq_a[i] !== exp_wr[i]) begin
          failures++; $display("FAIL rnd_reg_wr it=%0d idx=%0d got=%h exp=%h", it, i, (i < wrq_a.size()) ? wrq_a[i] : 12'hxxx, exp_wr[i]);
        end
      end
      bus_start();
      send_byte(8'h0A, 1'b1, a); send_byte(p, 1'b1, a); mptr = p % 16;
      bus_start();
      send_byte(8'h0B, 1'b1, a);
      for (int i = 0; i <= n; i++) begin
        e = mem[mptr];
        recv_byte(1'b1, (i < n), b);
        checks++; if (b !== e) begin failures++; $display("FAIL rnd_read it=%0d idx=%0d got=%h exp=%h", it, i, b, e); end
        if (i < n) mptr = (mptr + 1) % 16;
      end
      bus_stop();
      // The pointer survives the STOP: a read with no pointer byte continues from it.
      bus_start();
      send_byte(8'h0B, 1'b1, a);
      e = mem[mptr];
      recv_byte(1'b1, 1'b0, b);
      bus_stop();
      checks++; if (b !== e) begin failures++; $display("FAIL rnd_persist_ptr it=%0d got=%h exp=%h", it, b, e); end
    end
  endtask

  task automatic test_lsb_first();
    logic a0, a1, a2, a3, a4, a5;
    logic [7:0] b;
    @(negedge clk) RESET = 1'b1;
    clks(2);
    RESET = 1'b0;
    m_clear();
    clks(4);
    sel = 1'b1;
    bus_start();
    send_byte(8'h0A, 1'b0, a0); send_byte(8'h00, 1'b0, a1); send_byte(8'hCC, 1'b0, a2);
    bus_stop();
    checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL lsb_acks got=%b exp=111", {a0, a1, a2}); end
    rd_addr_b = 4'd0; clks(2);
    checks++; if (rd_data_b !== 8'hCC) begin failures++; $display("FAIL lsb_reg0 got=%h exp=cc", rd_data_b); end
    bus_start();
    send_byte(8'h0A, 1'b0, a3); send_byte(8'h00, 1'b0, a4);
    bus_start();
    send_byte(8'h0B, 1'b0, a5);
    recv_byte(1'b0, 1'b0, b);
    bus_stop();
    checks++; if (b !== 8'hCC) begin failures++; $display("FAIL lsb_readback got=%h exp=cc", b); end
    checks++; if ({a3, a4, a5} !== 3'b111) begin failures++; $display("FAIL lsb_read_acks got=%b exp=111", {a3, a4, a5}); end
    sel = 1'b0;
  endtask

  task automatic test_abort();
    logic a, rb;
    logic [7:0] v;
    int oe0, bad;
    bus_start();
    send_byte(8'h0A, 1'b1, a); send_byte(8'h05, 1'b1, a); mptr = 5;
    send_byte(8'h2C, 1'b1, a); m_write(8'h2C);
    send_byte(8'h77, 1'b1, a); m_write(8'h77);
    bus_stop();
    bus_start();
    send_byte(8'h0A, 1'b1, a); send_byte(8'h05, 1'b1, a);
    bus_start();
    send_byte(8'h0B, 1'b1, a);
    for (int i = 0; i < 3; i++) bus_bit(1'b1, rb);
    clks(Q); sda_m = 1'b1;
    clks(Q); scl_m = 1'b1;
    clks(Q);
    checks++; if (sda_oe_a !== ~mem[5][4]) begin failures++; $display("FAIL abort_driving_bit3 got=%b exp=%b", sda_oe_a, ~mem[5][4]); end
    RESET = 1'b1;
    @(negedge clk);
    RESET = 1'b0;
    m_clear();
    checks++; if (sda_oe_a !== 1'b0) begin failures++; $display("FAIL abort_sda_oe got=%b exp=0", sda_oe_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy_a); end
    clks(Q); scl_m = 1'b0;
    for (int i = 0; i < 5; i++) bus_bit(1'b1, rb);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      read_reg_a(i, v);
      if (v !== mem[i]) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL abort_regs_cleared got=%0d nonzero exp=0", bad); end
    oe0 = oe_cnt_a; wrq_a.delete();
    send_byte(8'h0A, 1'b1, a);
    checks++; if (a !== 1'b0) begin failures++; $display("FAIL abort_no_ack_without_start got=%b exp=0", a); end
    send_byte(8'h05, 1'b1, a);
    send_byte(8'h99, 1'b1, a);
    checks++; if (oe_cnt_a != oe0 || wrq_a.size() != 0) begin
      failures++; $display("FAIL abort_idle_traffic oe_cycles got=%0d exp=%0d writes=%0d", oe_cnt_a - oe0, 0, wrq_a.size());
    end
    bus_stop();
    bus_start();
    send_byte(8'h0A, 1'b1, a);
    bus_stop();
    checks++; if (a !== 1'b1) begin failures++; $display("FAIL abort_ack_after_new_start got=%b exp=1", a); end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_repeated_start_read();
    test_mismatch();
    test_wrap();
    test_random_bursts();
    test_lsb_first();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
- Parametrised next-generation I2C target (slave).
- Runs from one system clock and oversamples SCL/SDA rather than being clocked by SCL.
- Supports a configurable target address, an internal byte register file with auto-incrementing pointer, full ACK/NACK handling, repeated START, and multi-byte read/write bursts.
- Sits between the board-level open-drain I2C pins and local logic, which observes writes and reads registers in parallel.

Parameters:
- SLAVE_ADDR, 7'h05, 7-bit target address matched after START.
- DEPTH, 16, number of 8-bit registers; power of two, 2..256; PTR_W = log2(DEPTH) (localparam).
- MSB_FIRST, 1, 1 = standard MSB-first bit order on the bus; 0 = LSB-first legacy mode. Applies to address, pointer and data bytes.

Ports:
- clk  input  1  system clock; must be ≥ 8× SCL frequency.
- RESET  input  1  synchronous, active-high reset.
- scl_i  input  1  SCL pin level, asynchronous.
- sda_i  input  1  SDA pin level, asynchronous.
- sda_oe  output  1  1 = pull SDA low; 0 = release (pad is open-drain).
- busy  output  1  high from START with address match until STOP / NACK-exit.
- reg_wr  output  1  one-clk pulse when a data byte is written.
- reg_wr_addr  output  PTR_W  register index written.
- reg_wr_data  output  8  byte written.
- rd_addr  input  PTR_W  local parallel read index.
- rd_data  output  8  regfile[rd_addr], registered (1 clk latency).

Behaviour:
- Reset (clk edge with RESET=1): sda_oe=0, busy=0, reg_wr=0, reg_wr_addr=0, reg_wr_data=0, rd_data=0, all registers=0, pointer=0, state=IDLE. Reset mid-transaction aborts immediately; the bus is released on the same edge.
- Input path: 2-flop synchroniser on scl_i/sda_i plus a previous-value flop. Bus events are detected 3 clk after the pin changes.
- START: synced SDA falls while synced SCL is high. Legal from any state, including repeated START; always goes to ADDR and clears the bit counter.
- STOP: synced SDA rises while synced SCL is high. From any state: go to IDLE, sda_oe=0, busy=0.
- Sampling: bits are sampled on the synced SCL rising edge. sda_oe changes only on synced SCL falling edges.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK.
  - ADDR: shift 8 bits (7 address bits + R/W).
    - Match: set busy. On the next SCL fall, assert sda_oe (ACK) and go to ADDR_ACK.
    - Mismatch: stay released and go to IDLE (ignore traffic until the next START).
  - ADDR_ACK: on the SCL fall ending the ACK clock:
    - R/W=0: release and go to PTR.
    - R/W=1: load shift register from regfile[pointer], drive its first bit, go to RDATA.
  - PTR: 8 bits; pointer = low PTR_W bits of the byte (upper bits ignored). ACK, then WDATA.
  - WDATA: 8 bits. One clk after the 8th bit sample: write regfile[pointer], pulse reg_wr with addr/data, then pointer++. ACK is always given; go to WDATA_ACK, then WDATA.
  - RDATA: on each SCL fall, sda_oe = ~bit. After 8 bits, release SDA and go to RACK.
  - RACK: sample master SDA on SCL rise.
    - Low (ACK): pointer++, load next byte, drive its first bit on SCL fall, return to RDATA.
    - High (NACK): release and go to IDLE (busy=0).
- Pointer wraps DEPTH-1 → 0 on both write and read increment.
- Pointer persists across transactions; it is cleared only by reset.
- rd_data returns the regfile value after any same-clk write (write-first).
- A START arriving mid-byte discards the partial byte; no reg_wr is issued.

Test Plan:
- Write burst: START, 0x0A (addr 0x05, W), ptr 0x03, data 0xCC, 0x5A, STOP.
  - ACK on all 4 bytes.
  - reg_wr pulses with (3,0xCC) then (4,0x5A).
  - rd_addr=4 gives rd_data=0x5A after 1 clk.
- Repeated-START read: START, 0x0A, ptr 0x03, Sr, 0x0B, master ACK then NACK.
  - Bus bits are 0xCC then 0x5A.
  - busy drops after the NACK.
- Address mismatch: START, 0x0C, then 0xFF bytes.
  - sda_oe stays 0 throughout; no reg_wr; busy stays 0.
- Wrap-around with DEPTH=16: ptr 0x0F, write 0x11, 0x22.
  - Registers 15=0x11 and 0=0x22.
  - Pointer 0x1F with DEPTH=16 behaves as 0x0F.
- LSB-first mode (MSB_FIRST=0): address byte sent LSB first (bits 0,1,0,1,0,0,0,0), then data 0xCC LSB first.
  - ACK is given; register 0 (ptr byte 0x00) = 0xCC.
- Abort: assert RESET during the 4th data bit of a read.
  - sda_oe=0 on the next clk; all registers=0.
  - No ACK on the following traffic until a new START.
